// File: rtl/mac_array.sv
// Multi-lane fixed-point dot-product engine: one shared coefficient buffer, LANES signal
// lanes, coefficient replay every TAPS beats, saturating Q-format results with valid/ready.
module mac_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 4,
  parameter int LANES      = 4,
  parameter int FRAC_BITS  = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_LINES
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        start_i,
  input  logic                        reuse_i,
  input  logic                        abort_i,
  input  logic [ADDR_LINES-1:0]       cfg_taps_i,
  input  logic                        coeff_valid_i,
  input  logic [DATA_WIDTH-1:0]       coeff_data_i,
  output logic                        coeff_ready_o,
  input  logic                        sig_valid_i,
  input  logic [LANES*DATA_WIDTH-1:0] sig_data_i,
  output logic                        sig_ready_o,
  output logic                        res_valid_o,
  output logic [LANES*DATA_WIDTH-1:0] res_data_o,
  input  logic                        res_ready_i,
  output logic [LANES-1:0]            res_sat_o,
  output logic                        busy_o,
  output logic                        coeff_loaded_o
);

  localparam int PW = 2*DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                        state, state_nxt;
  logic [ADDR_LINES-1:0]         taps_m1, wr_ptr, rd_ptr;
  logic signed [DATA_WIDTH-1:0]  coeff_mem [2**ADDR_LINES];
  logic signed [DATA_WIDTH-1:0]  coeff_rd;
  logic signed [PW-1:0]          prod     [LANES];
  logic signed [PW-1:0]          prod_nxt [LANES];
  logic signed [ACC_WIDTH-1:0]   acc      [LANES];
  logic signed [ACC_WIDTH-1:0]   sum      [LANES];
  logic signed [ACC_WIDTH-1:0]   shifted  [LANES];
  logic                          prod_valid, prod_last;
  logic                          res_valid, coeff_loaded;
  logic [LANES*DATA_WIDTH-1:0]   res_data, res_nxt;
  logic [LANES-1:0]              res_sat, sat_nxt;
  logic                          coeff_fire, load_done, sig_ready, sig_fire, rd_last;

  assign coeff_fire = coeff_valid_i && (state == LOAD);
  assign load_done  = coeff_fire && (wr_ptr == taps_m1);
  assign rd_last    = (rd_ptr == taps_m1);
  // A last tap in the product stage forces the one-cycle bubble between frames.
  assign sig_ready  = (state == RUN) && !(res_valid && !res_ready_i)
                      && !(prod_valid && prod_last) && !abort_i;
  assign sig_fire   = sig_valid_i && sig_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_i) state_nxt = (reuse_i && coeff_loaded) ? RUN : LOAD;
      LOAD:    if (load_done) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (abort_i) state_nxt = IDLE;
  end

  always_comb begin
    coeff_rd = coeff_mem[rd_ptr];
    res_nxt  = '0;
    sat_nxt  = '0;
    for (int k = 0; k < LANES; k++) begin
      prod_nxt[k] = PW'($signed(sig_data_i[k*DATA_WIDTH +: DATA_WIDTH])) * PW'(coeff_rd);
      sum[k]      = acc[k] + ACC_WIDTH'(prod[k]);
      shifted[k]  = sum[k] >>> FRAC_BITS;
      if (shifted[k] > SAT_MAX) begin
        res_nxt[k*DATA_WIDTH +: DATA_WIDTH] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        sat_nxt[k] = 1'b1;
      end else if (shifted[k] < SAT_MIN) begin
        res_nxt[k*DATA_WIDTH +: DATA_WIDTH] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        sat_nxt[k] = 1'b1;
      end else begin
        res_nxt[k*DATA_WIDTH +: DATA_WIDTH] = shifted[k][DATA_WIDTH-1:0];
      end
    end
  end

  // NOTE: the coefficient RAM has no reset; its contents are only read after a full load.
  always_ff @(posedge clk_i) begin
    if (coeff_fire) coeff_mem[wr_ptr] <= coeff_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      taps_m1      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      prod_valid   <= 1'b0;
      prod_last    <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_sat      <= '0;
      coeff_loaded <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        prod[k] <= '0;
        acc[k]  <= '0;
      end
    end else begin
      state <= state_nxt;
      if (abort_i) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        prod_valid <= 1'b0;
        prod_last  <= 1'b0;
        res_valid  <= 1'b0;
        if (state == LOAD) coeff_loaded <= 1'b0;
        for (int k = 0; k < LANES; k++) begin
          prod[k] <= '0;
          acc[k]  <= '0;
        end
      end else begin
        if (state == IDLE && start_i) begin
          taps_m1 <= cfg_taps_i;
          wr_ptr  <= '0;
          if (!(reuse_i && coeff_loaded)) coeff_loaded <= 1'b0;
        end
        if (coeff_fire) begin
          wr_ptr <= load_done ? '0 : wr_ptr + 1'b1;
          if (load_done) coeff_loaded <= 1'b1;
        end
        if (sig_fire) begin
          rd_ptr <= rd_last ? '0 : rd_ptr + 1'b1;
          for (int k = 0; k < LANES; k++) prod[k] <= prod_nxt[k];
        end
        prod_valid <= sig_fire;
        prod_last  <= sig_fire && rd_last;
        if (prod_valid) begin
          for (int k = 0; k < LANES; k++) acc[k] <= prod_last ? '0 : sum[k];
        end
        // A new result may land in the same cycle the previous one is consumed.
        if (prod_valid && prod_last) begin
          res_valid <= 1'b1;
          res_data  <= res_nxt;
          res_sat   <= sat_nxt;
        end else if (res_valid && res_ready_i) begin
          res_valid <= 1'b0;
        end
      end
    end
  end

  assign coeff_ready_o  = (state == LOAD);
  assign sig_ready_o    = sig_ready;
  assign res_valid_o    = res_valid;
  assign res_data_o     = res_data;
  assign res_sat_o      = res_sat;
  assign busy_o         = (state != IDLE) || prod_valid || res_valid;
  assign coeff_loaded_o = coeff_loaded;

endmodule

// File: tb/tb_mac_array.sv
// Randomized bench for mac_array: a frame-level dot-product model predicts every result,
// plus directed latency, throughput, stall, saturation, reuse, abort and reset scenarios.
module tb_mac_array;
  localparam int DW = 32;
  localparam int AL = 4;
  localparam int L  = 4;
  localparam int FB = 16;

  logic            clk_i = 1'b0;
  logic            rstn_i, start_i, reuse_i, abort_i;
  logic [AL-1:0]   cfg_taps_i;
  logic            coeff_valid_i, coeff_ready_o;
  logic [DW-1:0]   coeff_data_i;
  logic            sig_valid_i, sig_ready_o;
  logic [L*DW-1:0] sig_data_i, res_data_o;
  logic            res_valid_o, res_ready_i, busy_o, coeff_loaded_o;
  logic [L-1:0]    res_sat_o;

  mac_array #(.DATA_WIDTH(DW), .ADDR_LINES(AL), .LANES(L), .FRAC_BITS(FB)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .reuse_i(reuse_i), .abort_i(abort_i),
    .cfg_taps_i(cfg_taps_i), .coeff_valid_i(coeff_valid_i), .coeff_data_i(coeff_data_i),
    .coeff_ready_o(coeff_ready_o), .sig_valid_i(sig_valid_i), .sig_data_i(sig_data_i),
    .sig_ready_o(sig_ready_o), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
    .res_ready_i(res_ready_i), .res_sat_o(res_sat_o), .busy_o(busy_o),
    .coeff_loaded_o(coeff_loaded_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   sat;
  } res_t;

  logic [31:0]  cm [16];
  logic [127:0] fbuf [16];
  res_t         expq [$];
  int           wi, nb, taps_m, sig_fires;
  bit           loaded_m, loading;
  bit           hold_prev;
  logic [127:0] hold_data;
  logic [3:0]   hold_sat;

  // Reference: plain wide-integer dot product over the captured frame, then shift and clamp.
  function automatic res_t model_frame();
    res_t r;
    logic signed [127:0] s, v;
    r = '0;
    for (int k = 0; k < L; k++) begin
      s = '0;
      for (int j = 0; j < taps_m; j++)
        s = s + 128'($signed(fbuf[j][k*32 +: 32])) * 128'($signed(cm[j]));
      v = s >>> FB;
      if (v > 128'sh7fffffff) begin
        r.data[k*32 +: 32] = 32'h7fffffff;
        r.sat[k] = 1'b1;
      end else if (v < -128'sh80000000) begin
        r.data[k*32 +: 32] = 32'h80000000;
        r.sat[k] = 1'b1;
      end else begin
        r.data[k*32 +: 32] = v[31:0];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_q();
    logic [31:0] m;
    m = $urandom & 32'h0003_ffff;
    if ($urandom_range(0, 3) == 0) return $urandom;
    return ($urandom_range(0, 1) != 0) ? -m : m;
  endfunction

  function automatic logic [127:0] sig_pat(input int mode);
    logic [127:0] v;
    for (int k = 0; k < L; k++) begin
      case (mode)
        0:       v[k*32 +: 32] = 32'(k + 1) << 16;
        1:       v[k*32 +: 32] = (k < 2) ? 32'h7fff0000 : 32'h80000000;
        default: v[k*32 +: 32] = rnd_q();
      endcase
    end
    return v;
  endfunction

  // One clock: observe handshakes just before the edge, update the model, advance to negedge.
  task automatic cycle();
    res_t e;
    #1;
    if (!rstn_i || abort_i) begin
      nb = 0;
      expq.delete();
      hold_prev = 0;
      loading = 0;
      if (!rstn_i) loaded_m = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 128'(res_valid_o), 128'(1));
        check("hold_data", res_data_o, hold_data);
        check("hold_sat", 128'(res_sat_o), 128'(hold_sat));
      end
      if (res_valid_o && !res_ready_i) check("stall_sig_ready", 128'(sig_ready_o), 128'(0));
      if (coeff_valid_i && coeff_ready_o) begin
        cm[wi] = coeff_data_i;
        wi++;
        if (wi == taps_m) begin
          loading = 0;
          loaded_m = 1;
        end
      end
      if (sig_valid_i && sig_ready_o) begin
        fbuf[nb] = sig_data_i;
        nb++;
        sig_fires++;
        if (nb == taps_m) begin
          expq.push_back(model_frame());
          nb = 0;
        end
      end
      if (res_valid_o && res_ready_i) begin
        if (expq.size() == 0) begin
          check("res_unexpected", 128'(res_valid_o), 128'(0));
        end else begin
          e = expq.pop_front();
          check("res_data", res_data_o, e.data);
          check("res_sat", 128'(res_sat_o), 128'(e.sat));
        end
      end
      hold_prev = res_valid_o && !res_ready_i;
      hold_data = res_data_o;
      hold_sat  = res_sat_o;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_abort();
    abort_i = 1'b1;
    cycle();
    abort_i = 1'b0;
  endtask

  task automatic do_start(input int cfg, input bit reuse);
    cfg_taps_i = AL'(cfg);
    reuse_i    = reuse;
    start_i    = 1'b1;
    taps_m     = cfg + 1;
    if (!(reuse && loaded_m)) begin
      loading  = 1;
      loaded_m = 0;
      wi       = 0;
    end
    cycle();
    start_i = 1'b0;
    reuse_i = 1'b0;
  endtask

  task automatic load(input int mode);
    int g;
    g = 0;
    while (loading && g < 200) begin
      coeff_valid_i = ($urandom_range(0, 3) != 0);
      case (mode)
        0:       coeff_data_i = 32'(wi + 1) << 16;
        1:       coeff_data_i = 32'h7fff0000;
        default: coeff_data_i = rnd_q();
      endcase
      cycle();
      g++;
    end
    coeff_valid_i = 1'b0;
    check("load_done", 128'(coeff_loaded_o), 128'(1));
  endtask

  task automatic run_beats(input int n, input int mode, input bit rnd_valid, input bit rnd_ready);
    int target, g;
    target = sig_fires + n;
    g = 0;
    while (sig_fires < target && g < 50*n + 100) begin
      sig_valid_i = rnd_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
      res_ready_i = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      sig_data_i  = sig_pat(mode);
      cycle();
      g++;
    end
    sig_valid_i = 1'b0;
    res_ready_i = 1'b1;
    check("beats_accepted", 128'(sig_fires), 128'(target));
  endtask

  task automatic drain();
    int g;
    g = 0;
    sig_valid_i = 1'b0;
    res_ready_i = 1'b1;
    while ((expq.size() != 0 || res_valid_o) && g < 60) begin
      cycle();
      g++;
    end
    check("drain_queue", 128'(expq.size()), 128'(0));
    check("drain_valid", 128'(res_valid_o), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] exp_v;
    int s, g;
    rstn_i = 1'b0; start_i = 1'b0; reuse_i = 1'b0; abort_i = 1'b0; cfg_taps_i = '0;
    coeff_valid_i = 1'b0; coeff_data_i = '0; sig_valid_i = 1'b0; sig_data_i = '0;
    res_ready_i = 1'b1;
    wi = 0; nb = 0; taps_m = 0; sig_fires = 0; loaded_m = 0; loading = 0; hold_prev = 0;
    @(negedge clk_i);
    cycle();
    cycle();
    rstn_i = 1'b1;

    check("rst_res_valid", 128'(res_valid_o), 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_loaded", 128'(coeff_loaded_o), 128'(0));
    check("rst_coeff_ready", 128'(coeff_ready_o), 128'(0));
    check("rst_sig_ready", 128'(sig_ready_o), 128'(0));
    check("rst_res_data", res_data_o, 128'(0));
    check("rst_res_sat", 128'(res_sat_o), 128'(0));

    // T1: 4 taps 1.0..4.0, lane k = (k+1).0, result after exactly two edges
    do_start(3, 0);
    check("t1_load_ready", 128'(coeff_ready_o), 128'(1));
    check("t1_load_loaded", 128'(coeff_loaded_o), 128'(0));
    load(0);
    check("t1_ready_off", 128'(coeff_ready_o), 128'(0));
    run_beats(3, 0, 0, 0);
    sig_valid_i = 1'b1;
    sig_data_i  = sig_pat(0);
    s = sig_fires;
    cycle();
    sig_valid_i = 1'b0;
    check("t1_fourth_beat", 128'(sig_fires), 128'(s + 1));
    check("t1_lat_early", 128'(res_valid_o), 128'(0));
    cycle();
    check("t1_lat", 128'(res_valid_o), 128'(1));
    for (int k = 0; k < L; k++) exp_v[k*32 +: 32] = 32'(10*(k + 1)) << 16;
    check("t1_data", res_data_o, exp_v);
    check("t1_sat", 128'(res_sat_o), 128'(0));
    drain();

    // T5: reuse skips LOAD; coeff beats offered meanwhile are ignored
    do_abort();
    check("t5_loaded_kept", 128'(coeff_loaded_o), 128'(1));
    do_start(3, 1);
    check("t5_no_load", 128'(coeff_ready_o), 128'(0));
    check("t5_in_run", 128'(sig_ready_o), 128'(1));
    coeff_valid_i = 1'b1;
    coeff_data_i  = 32'hdead_beef;
    run_beats(4, 0, 0, 0);
    coeff_valid_i = 1'b0;
    drain();

    // T2: 8 back-to-back frames: 32 beats plus 8 bubbles in 40 cycles
    res_ready_i = 1'b1;
    sig_valid_i = 1'b1;
    s = sig_fires;
    for (int c = 0; c < 40; c++) begin
      sig_data_i = sig_pat(2);
      cycle();
    end
    sig_valid_i = 1'b0;
    check("t2_beats", 128'(sig_fires - s), 128'(32));
    drain();

    // T3: sink stalls with a result pending
    res_ready_i = 1'b0;
    sig_valid_i = 1'b1;
    g = 0;
    while (!res_valid_o && g < 40) begin
      sig_data_i = sig_pat(2);
      cycle();
      g++;
    end
    check("t3_wait", 128'(res_valid_o), 128'(1));
    s = sig_fires;
    repeat (10) cycle();
    check("t3_no_accept", 128'(sig_fires), 128'(s));
    check("t3_sig_ready", 128'(sig_ready_o), 128'(0));
    run_beats(8, 2, 0, 0);
    drain();

    // T4: 16 taps at full scale: lanes 0,1 clip high, lanes 2,3 clip low
    do_abort();
    do_start(15, 0);
    load(1);
    run_beats(16, 1, 0, 0);
    g = 0;
    while (!res_valid_o && g < 10) begin
      cycle();
      g++;
    end
    check("t4_data", res_data_o, {32'h80000000, 32'h80000000, 32'h7fffffff, 32'h7fffffff});
    check("t4_sat", 128'(res_sat_o), 128'(4'hf));
    drain();

    // Random phase: taps 1, 16 and random, random valid/ready on both sides
    for (int it = 0; it < 4; it++) begin
      int cfg;
      cfg = (it == 0) ? 0 : (it == 1) ? 15 : $urandom_range(0, 15);
      do_abort();
      do_start(cfg, 0);
      load(2);
      if (cfg == 0) begin
        res_ready_i = 1'b1;
        sig_valid_i = 1'b1;
        s = sig_fires;
        for (int c = 0; c < 10; c++) begin
          sig_data_i = sig_pat(2);
          cycle();
        end
        sig_valid_i = 1'b0;
        check("taps1_rate", 128'(sig_fires - s), 128'(5));
      end
      run_beats((cfg + 1) * 3 + $urandom_range(0, 3), 2, 1, 1);
      drain();
    end

    // T6: abort mid-frame, abort in LOAD, reset in LOAD
    do_abort();
    do_start(3, 1);
    run_beats(2, 2, 0, 0);
    abort_i = 1'b1;
    sig_valid_i = 1'b1;
    cycle();
    abort_i = 1'b0;
    sig_valid_i = 1'b0;
    check("t6_abort_valid", 128'(res_valid_o), 128'(0));
    check("t6_abort_busy", 128'(busy_o), 128'(0));
    check("t6_abort_loaded", 128'(coeff_loaded_o), 128'(1));
    check("t6_abort_sig_ready", 128'(sig_ready_o), 128'(0));
    do_start(7, 0);
    check("t6_load_loaded", 128'(coeff_loaded_o), 128'(0));
    coeff_valid_i = 1'b1;
    coeff_data_i  = rnd_q();
    cycle();
    cycle();
    coeff_valid_i = 1'b0;
    do_abort();
    check("t6_abort_load_loaded", 128'(coeff_loaded_o), 128'(0));
    check("t6_abort_load_busy", 128'(busy_o), 128'(0));
    do_start(7, 0);
    coeff_valid_i = 1'b1;
    coeff_data_i  = rnd_q();
    cycle();
    coeff_valid_i = 1'b0;
    rstn_i = 1'b0;
    cycle();
    rstn_i = 1'b1;
    check("t6_rst_valid", 128'(res_valid_o), 128'(0));
    check("t6_rst_busy", 128'(busy_o), 128'(0));
    check("t6_rst_loaded", 128'(coeff_loaded_o), 128'(0));
    check("t6_rst_coeff_ready", 128'(coeff_ready_o), 128'(0));
    do_start(3, 1);
    check("t6_reuse_unloaded", 128'(coeff_ready_o), 128'(1));
    load(0);
    run_beats(4, 2, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
